clock_set_controller: RTL and testbench
=======================================

# clock_set_controller

Time-setting sequencer for the digital clock. Arbitrates the three front-panel buttons between normal running and a four-step digit-edit sequence. Drives the shared pause/add/subtract/select controls of the hour and minute counter chains, so that only one digit is modified at a time. Sits between the debounced button inputs and the counter/display datapath.

## Interface
Parameters:
- TIMEOUT_TICKS, default 10: `tick` pulses with no button activity before a SET state auto-exits to RUN; legal range 1..255.
- REPEAT_DLY, default 500: `clk` cycles a held up/down button must stay high before auto-repeat starts (≥2).
- REPEAT_RATE, default 100: `clk` cycles between auto-repeat pulses (≥2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- tick  input  1  one-cycle 1 Hz enable from the prescaler.
- btn_mode  input  1  debounced, clk-synchronous level; 1 = pressed.
- btn_up  input  1  debounced level; 1 = pressed.
- btn_down  input  1  debounced level; 1 = pressed.
- pause  output  1  1 in every SET state; freezes all counter chains.
- count_en  output  1  registered copy of `tick`, gated to RUN only.
- digit_sel  output  2  digit being edited: 3 = hour tens, 2 = hour ones, 1 = min tens, 0 = min ones.
- add_pulse  output  1  one-cycle increment command for `digit_sel`.
- sub_pulse  output  1  one-cycle decrement command for `digit_sel`.
- blink  output  1  1 = blank the selected digit on the display.
- set_done  output  1  one-cycle pulse on every SET→RUN transition.

## Operation
- FSM states: RUN, SET_HT, SET_HO, SET_MT, SET_MO.
  - Mode rising edge advances RUN→SET_HT→SET_HO→SET_MT→SET_MO→RUN.
  - `digit_sel` = 3/2/1/0 in SET_HT/HO/MT/MO and 0 in RUN.
- Edge detect: one register per button holds the previous sample. Edge = current & ~previous.
- In a SET state:
  - An up edge alone gives `add_pulse`.
  - A down edge alone gives `sub_pulse`.
  - Up and down both high in the same cycle: no pulse, and the repeat counter is cleared.
- In RUN: up/down are ignored and produce no pulses.
- Mode edge in the same cycle as an up/down edge: the state advances and the up/down edge is dropped.
- Idle counter:
  - Cleared on entry to any SET state and on every add/sub pulse.
  - Increments on `tick` while in SET.
  - On reaching TIMEOUT_TICKS: next state is RUN and `set_done` is pulsed.
- `blink`:
  - Cleared on entry to SET_HT and on every state advance.
  - Toggles on each `tick` while in SET.
  - Held 0 in RUN.
- `set_done` fires on the SET_MO→RUN mode step and on a timeout. It never fires from reset.

## Timing
- All outputs are registered.
- Reset values: state RUN, pause 0, count_en 0, digit_sel 0, add_pulse 0, sub_pulse 0, blink 0, set_done 0, all counters 0.
- Button latency: button sampled 1 at edge k (previous sample 0) → pulse high during cycle k+1 only.
  - State change on a mode edge is visible on `pause`/`digit_sel` at the same k+1 edge.
- `count_en` lags `tick` by exactly one cycle.
  - A tick coinciding with the edge that enters SET is suppressed.
  - A tick coinciding with the edge that returns to RUN is also suppressed (state-based gating on the registered next state).
- Timeout and mode edge in the same cycle: the mode transition wins. `set_done` pulses only if the resulting state is RUN.
- `reset` low mid-sequence: immediate return to RUN, and any in-flight pulse is cleared asynchronously.

## Configuration
- CLOCK_SET_AUTOREPEAT_EN defined:
  - While exactly one of up/down stays high in a SET state, a counter runs from the initial pulse.
  - After REPEAT_DLY cycles, a further pulse of the same kind is issued.
  - Then one pulse every REPEAT_RATE cycles until release or a state change.
  - Each repeat pulse clears the idle counter.
- Not defined: the repeat counter and its logic are absent; exactly one pulse per press.

## Test plan
- Reset low for 3 cycles, release, 5 ticks → all outputs 0 during reset; `count_en` pulses 5 times, each 1 cycle after `tick`.
- Mode pressed 5 times → `digit_sel` 3,2,1,0; `pause` 1 for four presses; 5th press gives pause 0 and a one-cycle `set_done`.
- In SET_MT: up press, down press, then both pressed together → one `add_pulse`, one `sub_pulse`, then no pulse.
- Enter SET_HT, apply 10 ticks with no buttons (TIMEOUT_TICKS=10) → RUN after 10th tick, `set_done` once, `blink` toggled 9 times then 0.
- With CLOCK_SET_AUTOREPEAT_EN, hold up 800 cycles (DLY 500, RATE 100) → add_pulse at cycles 1, 501, 601, 701; without the macro → exactly 1.
- Reset asserted in SET_MO during an `add_pulse` cycle → add_pulse, pause and digit_sel drop to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/clock_set_controller.sv
// Time-setting sequencer: arbitrates mode/up/down buttons between RUN and a four-digit edit sequence.
// Optional auto-repeat of held up/down buttons is enabled with `define CLOCK_SET_AUTOREPEAT_EN.
module clock_set_controller #(
  parameter int TIMEOUT_TICKS = 10,
  parameter int REPEAT_DLY    = 500,
  parameter int REPEAT_RATE   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       pause,
  output logic       count_en,
  output logic [1:0] digit_sel,
  output logic       add_pulse,
  output logic       sub_pulse,
  output logic       blink,
  output logic       set_done,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {RUN, SET_HT, SET_HO, SET_MT, SET_MO} state_t;

  if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255 || REPEAT_DLY < 2 || REPEAT_RATE < 2) begin : g_param_check
    $error("clock_set_controller: parameter out of range");
  end

  state_t     state, state_n;
  logic       mode_q, up_q, down_q;
  logic [7:0] idle_cnt, idle_cnt_n;
  logic       blink_n;
  logic       mode_edge, up_edge, down_edge, in_set;
  logic       edge_add, edge_sub, add_n, sub_n, pulse_now;
  logic       rpt_add, rpt_sub;

  assign mode_edge = btn_mode & ~mode_q;
  assign up_edge   = btn_up & ~up_q;
  assign down_edge = btn_down & ~down_q;
  assign in_set    = (state != RUN);
  assign state_dbg = state;

  // A mode edge always wins over a simultaneous up/down edge; pressing both buttons gives nothing.
  assign edge_add = in_set & ~mode_edge & up_edge & ~btn_down;
  assign edge_sub = in_set & ~mode_edge & down_edge & ~btn_up;

`ifdef CLOCK_SET_AUTOREPEAT_EN
  logic [15:0] rpt_cnt;
  logic        rpt_act, rpt_dir, rpt_fast, hold_match, rpt_fire;

  assign hold_match = in_set & ~mode_edge & (btn_up ^ btn_down) & (rpt_dir ? btn_up : btn_down);
  assign rpt_fire   = rpt_act & hold_match &
                      (rpt_cnt == (rpt_fast ? 16'(REPEAT_RATE - 1) : 16'(REPEAT_DLY - 1)));
  assign rpt_add    = rpt_fire & rpt_dir;
  assign rpt_sub    = rpt_fire & ~rpt_dir;

  // The counter is armed by the initial edge pulse and dies on release, both-pressed or state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt  <= '0;
      rpt_act  <= 1'b0;
      rpt_dir  <= 1'b0;
      rpt_fast <= 1'b0;
    end else if (edge_add || edge_sub) begin
      rpt_cnt  <= '0;
      rpt_act  <= 1'b1;
      rpt_dir  <= edge_add;
      rpt_fast <= 1'b0;
    end else if (rpt_act && hold_match && state_n == state) begin
      if (rpt_fire) begin
        rpt_cnt  <= '0;
        rpt_fast <= 1'b1;
      end else begin
        rpt_cnt  <= rpt_cnt + 16'd1;
      end
    end else begin
      rpt_cnt  <= '0;
      rpt_act  <= 1'b0;
      rpt_fast <= 1'b0;
    end
  end
`else
  assign rpt_add = 1'b0;
  assign rpt_sub = 1'b0;
`endif

  assign add_n     = edge_add | rpt_add;
  assign sub_n     = edge_sub | rpt_sub;
  assign pulse_now = add_n | sub_n;

  always_comb begin
    state_n = state;
    if (mode_edge) begin
      unique case (state)
        RUN:     state_n = SET_HT;
        SET_HT:  state_n = SET_HO;
        SET_HO:  state_n = SET_MT;
        SET_MT:  state_n = SET_MO;
        default: state_n = RUN;
      endcase
    end else if (in_set && tick && !pulse_now && idle_cnt == 8'(TIMEOUT_TICKS - 1)) begin
      state_n = RUN;
    end
  end

  always_comb begin
    idle_cnt_n = idle_cnt;
    blink_n    = blink;
    if (state_n == RUN || state_n != state) begin
      idle_cnt_n = '0;
      blink_n    = 1'b0;
    end else begin
      if (pulse_now)  idle_cnt_n = '0;
      else if (tick)  idle_cnt_n = idle_cnt + 8'd1;
      if (tick)       blink_n    = ~blink;
    end
  end

  // Outputs are registered from the next state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      mode_q    <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      idle_cnt  <= '0;
      blink     <= 1'b0;
      pause     <= 1'b0;
      count_en  <= 1'b0;
      digit_sel <= 2'd0;
      add_pulse <= 1'b0;
      sub_pulse <= 1'b0;
      set_done  <= 1'b0;
    end else begin
      state     <= state_n;
      mode_q    <= btn_mode;
      up_q      <= btn_up;
      down_q    <= btn_down;
      idle_cnt  <= idle_cnt_n;
      blink     <= blink_n;
      pause     <= (state_n != RUN);
      count_en  <= tick & (state == RUN) & (state_n == RUN);
      unique case (state_n)
        SET_HT:  digit_sel <= 2'd3;
        SET_HO:  digit_sel <= 2'd2;
        SET_MT:  digit_sel <= 2'd1;
        default: digit_sel <= 2'd0;
      endcase
      add_pulse <= add_n;
      sub_pulse <= sub_n;
      set_done  <= in_set & (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller; expectations adapt to CLOCK_SET_AUTOREPEAT_EN.
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       pause, count_en, add_pulse, sub_pulse, blink, set_done;
  logic [1:0] digit_sel;
  logic [2:0] state_dbg;

  int vectors = 0;
  int miscompares = 0;

  clock_set_controller #(.TIMEOUT_TICKS(10), .REPEAT_DLY(500), .REPEAT_RATE(100)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .pause(pause), .count_en(count_en), .digit_sel(digit_sel),
    .add_pulse(add_pulse), .sub_pulse(sub_pulse), .blink(blink),
    .set_done(set_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
  endtask

  initial begin
    int hits[$];
    int exp_at[4];
    int exp_n;
    int sub_seen;
    int ce_count;

    // Reset held for 3 cycles with tick active: everything must stay 0.
    tick = 1'b1;
    repeat (3) cyc();
    chk("rst_outs", {9'd0, pause, count_en, digit_sel, add_pulse, sub_pulse, blink, set_done}, 16'd0);
    chk("rst_state", 16'(state_dbg), 16'd0);
    tick = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();

    // Five ticks in RUN: count_en follows each by one cycle.
    ce_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk($sformatf("ce_hi%0d", i), 16'(count_en), 16'd1);
      if (count_en === 1'b1) ce_count++;
      cyc();
      chk($sformatf("ce_lo%0d", i), 16'(count_en), 16'd0);
    end
    chk("ce_count", 16'(ce_count), 16'd5);

    // Mode walk through all four digits and back to RUN.
    press_mode(); chk("m1_pause", 16'(pause), 16'd1); chk("m1_dsel", 16'(digit_sel), 16'd3);
    chk("m1_done", 16'(set_done), 16'd0); cyc();
    press_mode(); chk("m2_pause", 16'(pause), 16'd1); chk("m2_dsel", 16'(digit_sel), 16'd2); cyc();
    press_mode(); chk("m3_pause", 16'(pause), 16'd1); chk("m3_dsel", 16'(digit_sel), 16'd1); cyc();
    press_mode(); chk("m4_pause", 16'(pause), 16'd1); chk("m4_dsel", 16'(digit_sel), 16'd0);
    chk("m4_done", 16'(set_done), 16'd0); cyc();
    press_mode(); chk("m5_pause", 16'(pause), 16'd0); chk("m5_dsel", 16'(digit_sel), 16'd0);
    chk("m5_done", 16'(set_done), 16'd1);
    cyc(); chk("m5_done_off", 16'(set_done), 16'd0);

    // Up in RUN is ignored.
    btn_up = 1'b1; cyc(); chk("run_up", 16'({add_pulse, sub_pulse}), 16'd0);
    btn_up = 1'b0; cyc();

    // SET_MT: up, down, then both together.
    repeat (3) begin press_mode(); cyc(); end
    chk("mt_dsel", 16'(digit_sel), 16'd1);
    btn_up = 1'b1; cyc(); chk("mt_up", 16'({add_pulse, sub_pulse}), 16'b10);
    cyc(); chk("mt_up_once", 16'({add_pulse, sub_pulse}), 16'b00);
    btn_up = 1'b0; cyc();
    btn_down = 1'b1; cyc(); chk("mt_dn", 16'({add_pulse, sub_pulse}), 16'b01);
    cyc(); chk("mt_dn_once", 16'({add_pulse, sub_pulse}), 16'b00);
    btn_down = 1'b0; cyc();
    btn_up = 1'b1; btn_down = 1'b1; cyc(); chk("mt_both", 16'({add_pulse, sub_pulse}), 16'b00);
    cyc(); chk("mt_both2", 16'({add_pulse, sub_pulse}), 16'b00);
    btn_up = 1'b0; btn_down = 1'b0; cyc();

    // Mode and up edges together: state advances, up dropped.
    btn_mode = 1'b1; btn_up = 1'b1; cyc();
    chk("mu_dsel", 16'(digit_sel), 16'd0); chk("mu_pause", 16'(pause), 16'd1);
    chk("mu_add", 16'(add_pulse), 16'd0);
    btn_mode = 1'b0; btn_up = 1'b0; cyc();
    press_mode(); chk("mo_exit_done", 16'(set_done), 16'd1); chk("mo_exit_pause", 16'(pause), 16'd0);
    cyc();

    // Timeout from SET_HT after 10 idle ticks.
    press_mode(); chk("to_entry_blink", 16'(blink), 16'd0); cyc();
    for (int i = 1; i <= 10; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (i < 10) begin
        chk($sformatf("to_blink%0d", i), 16'(blink), 16'(i % 2));
        chk($sformatf("to_pause%0d", i), 16'(pause), 16'd1);
        chk($sformatf("to_done%0d", i), 16'(set_done), 16'd0);
      end else begin
        chk("to_exit_pause", 16'(pause), 16'd0);
        chk("to_exit_done", 16'(set_done), 16'd1);
        chk("to_exit_blink", 16'(blink), 16'd0);
        chk("to_exit_ce", 16'(count_en), 16'd0);
      end
      cyc();
    end
    chk("to_done_once", 16'(set_done), 16'd0);

    // Hold up for 800 cycles in SET_HT.
`ifdef CLOCK_SET_AUTOREPEAT_EN
    exp_n = 4; exp_at = '{1, 501, 601, 701};
`else
    exp_n = 1; exp_at = '{1, 0, 0, 0};
`endif
    press_mode(); cyc();
    sub_seen = 0;
    btn_up = 1'b1;
    for (int c = 1; c <= 800; c++) begin
      cyc();
      if (add_pulse === 1'b1) hits.push_back(c);
      if (sub_pulse === 1'b1) sub_seen++;
    end
    btn_up = 1'b0;
    cyc();
    chk("rpt_count", 16'(hits.size()), 16'(exp_n));
    chk("rpt_sub", 16'(sub_seen), 16'd0);
    for (int i = 0; i < exp_n; i++)
      chk($sformatf("rpt_at%0d", i), 16'((i < hits.size()) ? hits[i] : 0), 16'(exp_at[i]));

    // Asynchronous reset during an add_pulse in SET_MO.
    repeat (3) begin press_mode(); cyc(); end
    chk("ar_dsel_pre", 16'(digit_sel), 16'd0); chk("ar_state_pre", 16'(state_dbg), 16'd4);
    btn_up = 1'b1;
    cyc();
    chk("ar_add_pre", 16'(add_pulse), 16'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_add", 16'(add_pulse), 16'd0);
    chk("ar_pause", 16'(pause), 16'd0);
    chk("ar_dsel", 16'(digit_sel), 16'd0);
    chk("ar_state", 16'(state_dbg), 16'd0);
    btn_up = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    chk("ar_after", {9'd0, pause, count_en, digit_sel, add_pulse, sub_pulse, blink, set_done}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
